// File: rtl/delay_tracker.sv
// Averages ADC-edge misalignment samples over 2^AVG_LOG2 windows and integrates them into a clamped launch delay.
// Optional feature macro: DAMPED_STEP_EN (apply half of the averaged error per window).
module delay_tracker #(
    parameter int AVG_LOG2   = 2,
    parameter int MAX_DELAY  = 200,
    parameter int INIT_DELAY = 0,
    parameter int DEADBAND   = 1,
    parameter int LOCK_COUNT = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [15:0] misalign,
    input  logic        ready,
    output logic [7:0]  mismatch_delay,
    output logic        delay_ready,
    output logic        locked,
    output logic        sat_err
);
    localparam int ACC_W = 16 + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] CNT_LAST = {AVG_LOG2{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                    state_r;
    logic signed [ACC_W-1:0]   acc_r;
    logic [AVG_LOG2-1:0]       cnt_r;
    logic [3:0]                lock_cnt_r;
    logic                      ready_prev_r;
    logic [7:0]                delay_r;
    logic                      delay_ready_r;
    logic                      locked_r;
    logic                      sat_err_r;

    logic                      rise_s;
    logic signed [ACC_W-1:0]   misalign_ext_s;
    logic signed [15:0]        avg_s;
    logic signed [16:0]        avg_ext_s;
    logic [16:0]               avg_abs_s;
    logic                      in_band_s;
    logic signed [15:0]        step_s;
    logic signed [17:0]        sum_s;
    logic [7:0]                next_delay_s;
    logic                      clamp_s;

    assign rise_s         = ready & ~ready_prev_r;
    assign misalign_ext_s = $signed({{AVG_LOG2{misalign[15]}}, misalign});

    // Window average, deadband test and clamped next delay.
    always_comb begin
        avg_s     = 16'(acc_r >>> AVG_LOG2);
        avg_ext_s = {avg_s[15], avg_s};
        if (avg_ext_s[16]) begin
            avg_abs_s = 17'd0 - avg_ext_s;
        end else begin
            avg_abs_s = avg_ext_s;
        end
        in_band_s = (avg_abs_s <= 17'(DEADBAND));
`ifdef DAMPED_STEP_EN
        step_s = avg_s >>> 1;
`else
        step_s = avg_s;
`endif
        sum_s = $signed({10'd0, delay_r}) + $signed({{2{step_s[15]}}, step_s});
        if (sum_s < 18'sd0) begin
            next_delay_s = 8'd0;
            clamp_s      = 1'b1;
        end else if (sum_s > $signed(18'(MAX_DELAY))) begin
            next_delay_s = 8'(MAX_DELAY);
            clamp_s      = 1'b1;
        end else begin
            next_delay_s = sum_s[7:0];
            clamp_s      = 1'b0;
        end
    end

    // Sample/apply/handshake sequencer with all outputs registered.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            acc_r         <= ACC_W'(0);
            cnt_r         <= AVG_LOG2'(0);
            lock_cnt_r    <= 4'd0;
            ready_prev_r  <= 1'b0;
            delay_r       <= 8'(INIT_DELAY);
            delay_ready_r <= 1'b0;
            locked_r      <= 1'b0;
            sat_err_r     <= 1'b0;
        end else begin
            ready_prev_r <= ready;
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        acc_r <= acc_r + misalign_ext_s;
                        cnt_r <= cnt_r + AVG_LOG2'(1);
                        if (cnt_r == CNT_LAST) begin
                            state_r <= ST_APPLY;
                        end else begin
                            delay_ready_r <= ready;
                            state_r       <= ST_DONE;
                        end
                    end
                end
                ST_APPLY: begin
                    acc_r <= ACC_W'(0);
                    cnt_r <= AVG_LOG2'(0);
                    if (in_band_s) begin
                        if (lock_cnt_r < 4'(LOCK_COUNT)) begin
                            lock_cnt_r <= lock_cnt_r + 4'd1;
                        end
                        locked_r <= (({1'b0, lock_cnt_r} + 5'd1) >= 5'(LOCK_COUNT));
                    end else begin
                        delay_r    <= next_delay_s;
                        sat_err_r  <= sat_err_r | clamp_s;
                        lock_cnt_r <= 4'd0;
                        locked_r   <= 1'b0;
                    end
                    delay_ready_r <= 1'b1;
                    state_r       <= ST_DONE;
                end
                ST_DONE: begin
                    if (!ready) begin
                        delay_ready_r <= 1'b0;
                        state_r       <= ST_IDLE;
                    end
                end
                default: begin
                    delay_ready_r <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign mismatch_delay = delay_r;
    assign delay_ready    = delay_ready_r;
    assign locked         = locked_r;
    assign sat_err        = sat_err_r;
endmodule

// File: tb/tb_delay_tracker.sv
// Directed self-checking bench for delay_tracker at default parameters (full-gain build).
module tb_delay_tracker;
    logic        clk_in;
    logic        reset;
    logic [15:0] misalign;
    logic        ready;
    logic [7:0]  mismatch_delay;
    logic        delay_ready;
    logic        locked;
    logic        sat_err;

    int          n_checks;
    int          n_fail;
    logic [7:0]  cur_delay;

    delay_tracker dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .misalign       (misalign),
        .ready          (ready),
        .mismatch_delay (mismatch_delay),
        .delay_ready    (delay_ready),
        .locked         (locked),
        .sat_err        (sat_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset = 1'b1;
        ready = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        reset     = 1'b0;
        cur_delay = 8'd0;
    endtask

    // One measurement handshake; 'last' marks the window-completing sample.
    task automatic pulse(input logic [15:0] v, input bit last, input logic [7:0] exp_d);
        @(negedge clk_in);
        misalign = v;
        ready    = 1'b1;
        @(posedge clk_in);
        #1;
        if (!last) begin
            check("rdy_1cyc", {31'd0, delay_ready}, 32'd1);
            check("delay_hold", {24'd0, mismatch_delay}, {24'd0, cur_delay});
        end else begin
            check("rdy_not_early", {31'd0, delay_ready}, 32'd0);
            check("delay_pre", {24'd0, mismatch_delay}, {24'd0, cur_delay});
            @(posedge clk_in);
            #1;
            check("rdy_2cyc", {31'd0, delay_ready}, 32'd1);
            check("delay_new", {24'd0, mismatch_delay}, {24'd0, exp_d});
        end
        @(negedge clk_in);
        ready = 1'b0;
        @(posedge clk_in);
        #1;
        check("rdy_clear", {31'd0, delay_ready}, 32'd0);
    endtask

    task automatic window(input logic [15:0] v, input logic [7:0] exp_d);
        for (int i = 0; i < 3; i++) pulse(v, 1'b0, cur_delay);
        pulse(v, 1'b1, exp_d);
        cur_delay = exp_d;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cur_delay = 8'd0;
        reset     = 1'b1;
        ready     = 1'b0;
        misalign  = 16'd0;
        do_reset();
        @(posedge clk_in);
        #1;
        check("rst_delay", {24'd0, mismatch_delay}, 32'd0);
        check("rst_rdy", {31'd0, delay_ready}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_sat", {31'd0, sat_err}, 32'd0);
        repeat (20) @(posedge clk_in);
        #1;
        check("idle_delay", {24'd0, mismatch_delay}, 32'd0);
        check("idle_rdy", {31'd0, delay_ready}, 32'd0);

        // +3,+4,+5,+6: sum 18, floor(18/4) = 4
        pulse(16'sd3, 1'b0, 8'd0);
        pulse(16'sd4, 1'b0, 8'd0);
        pulse(16'sd5, 1'b0, 8'd0);
        pulse(16'sd6, 1'b1, 8'd4);
        cur_delay = 8'd4;
        check("sat_after_p4", {31'd0, sat_err}, 32'd0);

        // 4 - 20 underflows to 0
        window(-16'sd20, 8'd0);
        check("sat_low", {31'd0, sat_err}, 32'd1);
        window(16'sd95, 8'd95);
        window(16'sd95, 8'd190);
        check("sat_sticky", {31'd0, sat_err}, 32'd1);
        window(16'sd40, 8'd200);
        check("sat_high", {31'd0, sat_err}, 32'd1);

        // Lock sequence from a fresh reset
        do_reset();
        window(16'sd50, 8'd50);
        check("sat_cleared", {31'd0, sat_err}, 32'd0);
        for (int w = 1; w <= 4; w++) begin
            window(16'sd1, 8'd50);
            check($sformatf("locked_w%0d", w), {31'd0, locked}, (w == 4) ? 32'd1 : 32'd0);
        end
        window(16'sd5, 8'd55);
        check("unlock", {31'd0, locked}, 32'd0);
        window(-16'sd1, 8'd55);
        check("neg_band_nolock", {31'd0, locked}, 32'd0);
        // -1,-1,-1,-2: sum -5, floor gives -2 (outside deadband)
        pulse(-16'sd1, 1'b0, 8'd55);
        pulse(-16'sd1, 1'b0, 8'd55);
        pulse(-16'sd1, 1'b0, 8'd55);
        pulse(-16'sd2, 1'b1, 8'd53);
        cur_delay = 8'd53;
        check("sat_floor", {31'd0, sat_err}, 32'd0);

        // Partial window discarded by reset
        pulse(16'sd50, 1'b0, 8'd53);
        pulse(16'sd50, 1'b0, 8'd53);
        do_reset();
        @(posedge clk_in);
        #1;
        check("rst_mid_delay", {24'd0, mismatch_delay}, 32'd0);
        window(16'sd2, 8'd2);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
